config_bus_master: RTL and testbench

Initiator for the tile configuration bus. Accepts single read/write requests from a host-side valid/ready channel, drives `config_config_addr`, `config_config_data`, `config_write` and `config_read` into a core, samples the core's `read_config_data`, and returns one response per request on a valid/ready channel. It sits between the global configuration controller and each core's config port, the counterpart of the core-side config register file and readback mux.

---
 rtl/config_bus_master.sv | 133 +++++++++++++
 tb/tb_config_bus_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_bus_master.sv
// config_bus_master: host request/response channel to a tile config bus.
// One transaction outstanding at a time; every output comes from a register.
module config_bus_master #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_write,
  output logic [ADDR_WIDTH-1:0] config_config_addr,
  output logic [DATA_WIDTH-1:0] config_config_data,
  output logic                  config_write,
  output logic                  config_read,
  input  logic [DATA_WIDTH-1:0] read_config_data
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

  localparam logic [3:0] LAST = 4'(READ_LATENCY - 1);

  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic                  req_ready_d;
  logic                  resp_valid_d;
  logic                  resp_write_d;
  logic [DATA_WIDTH-1:0] resp_data_d;
  logic                  config_write_d;
  logic                  config_read_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;

  // next state and next registered output values
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    req_ready_d    = 1'b0;
    resp_valid_d   = 1'b0;
    resp_write_d   = resp_write;
    resp_data_d    = resp_data;
    config_write_d = 1'b0;
    config_read_d  = 1'b0;
    addr_d         = config_config_addr;
    data_d         = config_config_data;
    unique case (state)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          addr_d      = req_addr;
          if (req_write) begin
            data_d         = req_data;
            config_write_d = 1'b1;
            state_d        = WRITE;
          end else begin
            config_read_d = 1'b1;
            cnt_d         = '0;
            state_d       = READ;
          end
        end
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        resp_data_d  = '0;
        resp_write_d = 1'b1;
        state_d      = RESP;
      end
      READ: begin
        if (cnt == LAST) begin
          resp_valid_d = 1'b1;
          resp_data_d  = read_config_data;
          resp_write_d = 1'b0;
          state_d      = RESP;
        end else begin
          cnt_d         = cnt + 4'd1;
          config_read_d = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          req_ready_d  = 1'b1;
          resp_data_d  = '0;
          resp_write_d = 1'b0;
          state_d      = IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      req_ready          <= 1'b0;
      resp_valid         <= 1'b0;
      resp_write         <= 1'b0;
      resp_data          <= '0;
      config_write       <= 1'b0;
      config_read        <= 1'b0;
      config_config_addr <= '0;
      config_config_data <= '0;
    end else begin
      state              <= state_d;
      cnt                <= cnt_d;
      req_ready          <= req_ready_d;
      resp_valid         <= resp_valid_d;
      resp_write         <= resp_write_d;
      resp_data          <= resp_data_d;
      config_write       <= config_write_d;
      config_read        <= config_read_d;
      config_config_addr <= addr_d;
      config_config_data <= data_d;
    end
  end

endmodule

// File: tb/tb_config_bus_master.sv
// tb_config_bus_master: random and directed traffic against a
// transaction-timeline model, plus a short READ_LATENCY=1 check.
module tb_config_bus_master;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic        req_ready, resp_valid, resp_write, config_write, config_read;
  logic [31:0] resp_data, config_config_data, read_config_data;
  logic [7:0]  config_config_addr;

  logic        req_valid_b = 1'b0, req_write_b = 1'b0, resp_ready_b = 1'b0;
  logic [7:0]  req_addr_b = '0;
  logic [31:0] req_data_b = '0;
  logic        req_ready_b, resp_valid_b, resp_write_b;
  logic        config_write_b, config_read_b;
  logic [31:0] resp_data_b, config_config_data_b, read_config_data_b;
  logic [7:0]  config_config_addr_b;

  config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_write(resp_write),
    .config_config_addr(config_config_addr),
    .config_config_data(config_config_data),
    .config_write(config_write), .config_read(config_read),
    .read_config_data(read_config_data)
  );

  config_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_data(req_data_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_data(resp_data_b), .resp_write(resp_write_b),
    .config_config_addr(config_config_addr_b),
    .config_config_data(config_config_data_b),
    .config_write(config_write_b), .config_read(config_read_b),
    .read_config_data(read_config_data_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return {a, a, a, a} ^ 32'hA5A5_0000;
  endfunction

  // core for dut: register file whose readback lags the address by 2 cycles
  logic [31:0] ca [256];
  bit          wa [256];
  logic [31:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    if (config_write) begin
      ca[config_config_addr] <= config_config_data;
      wa[config_config_addr] <= 1'b1;
    end
    d1 <= wa[config_config_addr] ? ca[config_config_addr] : init_val(config_config_addr);
    d2 <= d1;
  end
  assign read_config_data = d2;

  // core for dut_b: combinational address-indexed readback
  logic [31:0] cb [256];
  bit          wb [256];
  always @(posedge clk) begin
    if (config_write_b) begin
      cb[config_config_addr_b] <= config_config_data_b;
      wb[config_config_addr_b] <= 1'b1;
    end
  end
  assign read_config_data_b = wb[config_config_addr_b] ?
    cb[config_config_addr_b] : init_val(config_config_addr_b);

  int n_chk = 0, n_pass = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  // transaction-timeline model: cycle c means the interval after edge c
  int          cyc = 0;
  int          m_t0 = 0;
  bit          m_busy = 0, m_wr = 0, m_rr = 0;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_cdata = '0, m_rdata = '0;
  logic [31:0] mem [int];

  function automatic logic [31:0] mem_rd(input logic [7:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : init_val(a);
  endfunction

  function automatic bit exp_rv(input int c);
    return m_busy && (c >= m_t0 + (m_wr ? 1 : LAT));
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_busy = 0; m_rr = 0; m_addr = '0; m_cdata = '0;
    end else begin
      cyc++;
      if (m_busy) begin
        if (resp_ready && exp_rv(cyc - 1)) m_busy = 0;
      end else if (m_rr && req_valid) begin
        m_busy = 1; m_wr = req_write; m_t0 = cyc; m_addr = req_addr;
        if (req_write) begin
          m_cdata = req_data; m_rdata = '0; mem[int'(req_addr)] = req_data;
        end else begin
          m_rdata = mem_rd(req_addr);
        end
      end
      m_rr = !m_busy;
    end
  end

  // per-cycle comparison of every dut output against the model
  initial forever begin
    bit rv, cw, cr;
    @(negedge clk);
    rv = exp_rv(cyc);
    cw = m_busy && m_wr && (cyc == m_t0);
    cr = m_busy && !m_wr && (cyc >= m_t0) && (cyc < m_t0 + LAT);
    check1("m_req_ready", req_ready, m_rr);
    check1("m_resp_valid", resp_valid, rv);
    check1("m_resp_write", resp_write, rv && m_wr);
    check32("m_resp_data", resp_data, rv ? m_rdata : 32'h0);
    check1("m_cfg_write", config_write, cw);
    check1("m_cfg_read", config_read, cr);
    check32("m_cfg_addr", {24'b0, config_config_addr}, {24'b0, m_addr});
    check32("m_cfg_data", config_config_data, m_cdata);
    check1("m_strobe_excl", config_write & config_read, 1'b0);
  end

  logic [31:0] rlog [$];
  initial forever begin
    @(posedge clk);
    if (!reset && resp_valid && resp_ready) rlog.push_back(resp_data);
  end

  int mode = 0;

  task automatic tick();
    @(negedge clk);
    if (mode == 0) resp_ready = 1'b1;
    else if (mode == 1) resp_ready = ($urandom_range(0, 3) != 0);
    else resp_ready = 1'b0;
  endtask

  task automatic send(input bit w, input logic [7:0] a, input logic [31:0] d, input bit hold);
    bit acc = 0;
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    while (!acc && n < 200) begin
      acc = req_ready;
      tick();
      n++;
    end
    check1("send_accept", acc, 1'b1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    check1("idle_reached", req_ready, 1'b1);
  endtask

  initial begin
    int cnt, base;
    reset = 1'b1;
    repeat (3) tick();
    check1("rst_req_ready", req_ready, 1'b0);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check32("rst_addr", {24'b0, config_config_addr}, 32'h0);
    reset = 1'b0;
    tick();
    check1("rel_req_ready", req_ready, 1'b1);

    // single write
    send(1'b1, 8'h01, 32'hDEADBEEF, 1'b0);
    check1("wr_strobe", config_write, 1'b1);
    check32("wr_addr", {24'b0, config_config_addr}, 32'h01);
    check32("wr_data", config_config_data, 32'hDEADBEEF);
    tick();
    check1("wr_strobe_once", config_write, 1'b0);
    check1("wr_resp_valid", resp_valid, 1'b1);
    check1("wr_resp_write", resp_write, 1'b1);
    check32("wr_resp_data", resp_data, 32'h0);
    tick();
    check32("core_reg1", wa[1] ? ca[1] : 32'h0, 32'hDEADBEEF);

    // latency 3: read 0x02 then 0x01 so readback must move past stale data
    send(1'b0, 8'h02, 32'h0, 1'b0);
    wait_idle();
    check32("rd2_log", rlog[rlog.size() - 1], 32'hA7A7_0202);
    send(1'b0, 8'h01, 32'h0, 1'b0);
    cnt = 1;
    for (int i = 0; i < 10 && !resp_valid; i++) begin
      tick();
      if (config_read) cnt++;
    end
    check32("lat3_strobes", 32'(cnt), 32'd3);
    check32("lat3_data", resp_data, 32'hDEADBEEF);
    wait_idle();

    // response backpressure
    mode = 2;
    send(1'b0, 8'h01, 32'h0, 1'b0);
    repeat (LAT) tick();
    for (int i = 0; i < 10; i++) begin
      check1("bp_valid", resp_valid, 1'b1);
      check32("bp_data", resp_data, 32'hDEADBEEF);
      check1("bp_ready", req_ready, 1'b0);
      check1("bp_strobes", config_write | config_read, 1'b0);
      tick();
    end
    mode = 0;
    resp_ready = 1'b1;
    tick();
    check1("bp_done_valid", resp_valid, 1'b0);
    check1("bp_done_ready", req_ready, 1'b1);

    // reset during the second read strobe cycle
    send(1'b0, 8'h03, 32'h0, 1'b0);
    tick();
    check1("mid_strobe", config_read, 1'b1);
    #2 reset = 1'b1;
    #1;
    check1("mid_rst_read", config_read, 1'b0);
    check1("mid_rst_valid", resp_valid, 1'b0);
    check32("mid_rst_addr", {24'b0, config_config_addr}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check1("mid_rel_ready", req_ready, 1'b1);
    cnt = 0;
    repeat (6) begin
      tick();
      if (resp_valid) cnt++;
    end
    check32("mid_no_resp", 32'(cnt), 32'd0);

    // back-to-back alternating traffic with req_valid held
    base = rlog.size();
    send(1'b1, 8'h10, 32'hA1A1A1A1, 1'b1);
    send(1'b0, 8'h10, 32'h0, 1'b1);
    send(1'b1, 8'h11, 32'hB2B2B2B2, 1'b1);
    send(1'b0, 8'h11, 32'h0, 1'b0);
    wait_idle();
    check32("b2b_count", 32'(rlog.size() - base), 32'd4);
    if (rlog.size() >= base + 4) begin
      check32("b2b_r0", rlog[base], 32'h0);
      check32("b2b_r1", rlog[base + 1], 32'hA1A1A1A1);
      check32("b2b_r2", rlog[base + 2], 32'h0);
      check32("b2b_r3", rlog[base + 3], 32'hB2B2B2B2);
    end

    // random traffic with random response backpressure
    mode = 1;
    for (int i = 0; i < 80; i++) begin
      bit hold;
      hold = ($urandom_range(0, 1) == 1);
      send($urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)), $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) tick();
    end
    req_valid = 1'b0;
    mode = 0;
    wait_idle();

    // READ_LATENCY=1 instance: write then read address 0
    check1("b_ready", req_ready_b, 1'b1);
    resp_ready_b = 1'b1;
    req_valid_b = 1'b1; req_write_b = 1'b1;
    req_addr_b = 8'h00; req_data_b = 32'h12345678;
    tick();
    req_valid_b = 1'b0;
    check1("b_wr_strobe", config_write_b, 1'b1);
    tick();
    check1("b_wr_resp", resp_valid_b, 1'b1);
    check1("b_wr_rw", resp_write_b, 1'b1);
    tick();
    check1("b_ready2", req_ready_b, 1'b1);
    req_valid_b = 1'b1; req_write_b = 1'b0;
    tick();
    req_valid_b = 1'b0;
    check1("b_rd_strobe", config_read_b, 1'b1);
    check1("b_rd_early", resp_valid_b, 1'b0);
    tick();
    check1("b_rd_strobe_once", config_read_b, 1'b0);
    check1("b_rd_valid", resp_valid_b, 1'b1);
    check32("b_rd_data", resp_data_b, 32'h12345678);
    check1("b_rd_rw", resp_write_b, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
